// File: rtl/sar_pkg.sv
// Shared types and helpers for the successive-approximation search controller.
package sar_pkg;

    localparam int unsigned SarWidthDefault = 8;

    typedef enum logic [1:0] {
        StIdle,
        StSearch,
        StDone
    } sar_state_e;

    // A comparator verdict is legal only when exactly one of the three lines is high.
    function automatic logic verdict_legal(input logic a_more, input logic b_more,
                                           input logic ab_equal);
        return (a_more ^ b_more ^ ab_equal) && !(a_more && b_more && ab_equal);
    endfunction

endpackage

// File: rtl/sar_search.sv
// Successive-approximation search: drives a trial value into an external comparator and
// rebuilds the target one bit per cycle, MSB first. Optional SAR_SEARCH_EARLY_EXIT_EN.
module sar_search
    import sar_pkg::*;
#(
    parameter int unsigned WIDTH = SarWidthDefault
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             a_more_i,
    input  logic             b_more_i,
    input  logic             ab_equal_i,
    output logic [WIDTH-1:0] trial_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             match_o,
    output logic             err_o
);

    localparam int unsigned IdxW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MsbOnly = WIDTH'(1) << (WIDTH - 1);

    sar_state_e       state_q;
    logic [IdxW-1:0]  idx_q;
    logic [WIDTH-1:0] trial_q;
    logic [WIDTH-1:0] result_q;
    logic             busy_q;
    logic             done_q;
    logic             match_q;
    logic             err_q;

    logic             legal;
    logic             equal_hit;
    logic             exit_now;
    logic [WIDTH-1:0] trial_d;

    always_comb begin
        legal     = verdict_legal(a_more_i, b_more_i, ab_equal_i);
        equal_hit = legal && ab_equal_i;
        trial_d   = trial_q;
        // Illegal verdicts clear the bit under test.
        trial_d[idx_q] = legal && (a_more_i || ab_equal_i);
`ifdef SAR_SEARCH_EARLY_EXIT_EN
        exit_now = (idx_q == '0) || equal_hit;
`else
        exit_now = (idx_q == '0);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            trial_q  <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            match_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        trial_q <= MsbOnly;
                        idx_q   <= IdxW'(WIDTH - 1);
                        match_q <= 1'b0;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= StSearch;
                    end
                end
                StSearch: begin
                    if (!legal) begin
                        err_q <= 1'b1;
                    end
                    if (equal_hit) begin
                        match_q <= 1'b1;
                    end
                    if (exit_now) begin
                        // On an early exit trial_d equals trial_q: the kept bit is already set.
                        trial_q  <= trial_d;
                        result_q <= trial_d;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= StDone;
                    end else begin
                        trial_q <= trial_d | (WIDTH'(1) << (idx_q - IdxW'(1)));
                        idx_q   <= idx_q - IdxW'(1);
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign trial_o  = trial_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign result_o = result_q;
    assign match_o  = match_q;
    assign err_o    = err_q;

endmodule

// File: tb/tb_sar_search.sv
// Self-checking bench for sar_search: combinational comparator model plus a bit-serial
// reference of the search, randomized targets and injected illegal verdicts.
module tb_sar_search;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         a_more;
    logic         b_more;
    logic         ab_equal;
    logic [W-1:0] trial;
    logic [W-1:0] result;
    logic         busy;
    logic         done;
    logic         match;
    logic         err;

    logic [W-1:0] target;
    bit           force_low;
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] exp_trials[$];

    always #5 clk = ~clk;

    always_comb begin
        a_more   = !force_low && (target > trial);
        b_more   = !force_low && (target < trial);
        ab_equal = !force_low && (target == trial);
    end

    sar_search #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start),
        .a_more_i  (a_more),
        .b_more_i  (b_more),
        .ab_equal_i(ab_equal),
        .trial_o   (trial),
        .busy_o    (busy),
        .done_o    (done),
        .result_o  (result),
        .match_o   (match),
        .err_o     (err)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
            $error("check %s failed", tag);
        end
    endtask

    // Bit-serial reference: decide each bit from target >= candidate; inj marks the
    // verdict cycle (1..W) whose verdict is forced all-low, 0 for none.
    task automatic model(input logic [W-1:0] tgt, input int inj, output logic [W-1:0] res,
                         output bit m, output bit e, output int done_cyc);
        logic [W-1:0] t;
        int           step;
        res      = '0;
        m        = 1'b0;
        e        = 1'b0;
        done_cyc = W + 1;
        exp_trials.delete();
        for (int k = W - 1; k >= 0; k--) begin
            t    = res | (W'(1) << k);
            step = W - k;
            exp_trials.push_back(t);
            if (step == inj) begin
                e = 1'b1;
            end else if (tgt >= t) begin
                res = t;
                if (tgt == t) begin
                    m = 1'b1;
`ifdef SAR_SEARCH_EARLY_EXIT_EN
                    done_cyc = step + 1;
                    break;
`endif
                end
            end
        end
    endtask

    task automatic run_search(input logic [W-1:0] tgt, input int inj);
        logic [W-1:0] m_res;
        bit           m_match;
        bit           m_err;
        int           m_done;
        int           cyc;
        bit           seen;
        model(tgt, inj, m_res, m_match, m_err, m_done);
        target = tgt;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        seen  = 1'b0;
        chk("busy_rise", int'(busy), 1);
        while (cyc <= 2 * W) begin
            force_low = (cyc == inj);
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (cyc <= exp_trials.size()) chk("trial", int'(trial), int'(exp_trials[cyc-1]));
            @(negedge clk);
            cyc++;
        end
        force_low = 1'b0;
        chk("done_seen", int'(seen), 1);
        chk("done_cycle", cyc, m_done);
        chk("result", int'(result), int'(m_res));
        chk("match", int'(match), int'(m_match));
        chk("err", int'(err), int'(m_err));
        chk("busy_at_done", int'(busy), 0);
        @(negedge clk);
        chk("done_pulse", int'(done), 0);
        chk("result_hold", int'(result), int'(m_res));
    endtask

    initial begin
        int inj;
        int c;
        int last_done;
        rst       = 1'b0;
        start     = 1'b0;
        force_low = 1'b0;
        target    = '0;
        #2 rst = 1'b1;
        #1;
        chk("rst_trial", int'(trial), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_match", int'(match), 0);
        chk("rst_err", int'(err), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed targets from the plan
        run_search(8'hA5, 0);
        chk("a5_result", int'(result), 'hA5);
        chk("a5_match", int'(match), 1);
        run_search(8'h00, 0);
        chk("zero_match", int'(match), 0);
        run_search(8'hFF, 0);
        chk("ff_result", int'(result), 'hFF);
        run_search(8'h80, 0);
        chk("msb_result", int'(result), 'h80);
        // Verdict cycle 3 forced low: bit 5 cleared, err reported
        run_search(8'h5A, 3);
        chk("inj_err", int'(err), 1);
        chk("inj_result", int'(result), 'h5A);
        run_search(8'hA5, 3);

        // Reset in the middle of a search discards it
        target = 8'h3C;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_trial", int'(trial), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_result", int'(result), 0);
        chk("mid_rst_match", int'(match), 0);
        @(negedge clk);
        rst = 1'b0;
        run_search(8'h3C, 0);

        // Randomized targets with occasional illegal verdicts
        for (int n = 0; n < 24; n++) begin
            inj = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W)) : 0;
            run_search(W'($urandom), inj);
        end

        // start held high: a search every W+2 cycles, nothing extra queued
        target = 8'h00;
        @(negedge clk);
        start     = 1'b1;
        last_done = 0;
        for (c = 1; c <= 4 * (W + 2); c++) begin
            @(negedge clk);
            chk("held_busy", int'(busy), int'(((c - 1) % (W + 2)) < W));
            chk("held_done", int'(done), int'(((c - 1) % (W + 2)) == W));
            if (done) begin
                if (last_done != 0) chk("held_period", c - last_done, W + 2);
                last_done = c;
            end
        end
        start = 1'b0;
        chk("held_result", int'(result), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
